mem_stage: RTL
==============

Name: mem_stage

Overview:
Pipeline MEM stage, directly downstream of the EX stage. It consumes the EX/MEM register (ex_mem_stage_reg_t) and issues load/store requests to the data-memory port. It waits for the memory response, aligns and extends load data, and registers the result into the MEM/WB register (mem_wb_stage_reg_t). It asserts a stall to freeze upstream stages while a data access is outstanding.

Parameters:
- DMEM_TIMEOUT, 0, cycles to wait before flagging a hung access; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ex_mem  in  ex_mem_stage_reg_t  EX/MEM register contents; held stable by upstream while mem_stall=1.
- dmem_addr  out  32  word-aligned address {alu_out[31:2],2'b00}.
- dmem_rmask  out  4  load byte mask.
- dmem_wmask  out  4  store byte mask.
- dmem_wdata  out  32  store data, lane-shifted.
- dmem_rdata  in  32  load data; valid when dmem_resp=1.
- dmem_resp  in  1  access complete.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_wb  out  mem_wb_stage_reg_t  registered MEM/WB contents.
- mem_timeout  out  1  sticky; DMEM_TIMEOUT exceeded.

Behaviour:
- Access classification: is_load = ex_mem.valid && opcode==op_load. is_store = ex_mem.valid && opcode==op_store. off = alu_out[1:0].
- Byte, halfword and word masks are 4'b0001, 4'b0011 and 4'b1111, each shifted left by off.
- Store data: sb = rs2_v[7:0] replicated to all lanes; sh = rs2_v[15:0] replicated to both halves; sw = rs2_v.
- Misaligned access (half with off[0]=1, or word with off!=0):
  - No request is issued; masks stay 0.
  - mem_wb.valid=1 with mem_wb.misaligned=1; the result proceeds with no stall.
- FSM with two states, IDLE and WAIT.
- IDLE:
  - Masks are driven combinationally for one cycle when an aligned access is present.
  - If dmem_resp=1 in that same cycle, the access completes: mem_stall=0, and mem_wb is latched at the edge.
  - Otherwise mem_stall=1 and the FSM goes to WAIT.
- WAIT:
  - Masks are 0; the request is never reissued.
  - mem_stall=1 until the cycle in which dmem_resp=1.
  - In that cycle mem_stall=0, mem_wb latches the result, and the FSM returns to IDLE.
- Load extension:
  - Extract byte or halfword at lane off.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - The result goes to mem_wb.mem_rdata.
- Non-memory instructions pass through in 1 cycle with no stall.
- Pass-through fields: pc, inst, rd_s, regf_we, regfilemux_sel, alu_out, br_en, u_imm, and the phys/arch rename fields copy unchanged.
- mem_wb.valid = ex_mem.valid, except that it is 0 in any cycle with mem_stall=1; the stage inserts a bubble.
- Flush: flushed instructions arrive with ex_mem.valid=0. An access already in WAIT always completes; it is never abandoned.
- Timeout: a counter runs in WAIT. If DMEM_TIMEOUT≠0 and the count reaches DMEM_TIMEOUT, mem_timeout sets. The FSM keeps waiting.
- Reset (rst_n=0, any state, including mid-WAIT):
  - FSM returns to IDLE; counter and mem_timeout clear.
  - All mem_wb fields are 0.
  - dmem_rmask/dmem_wmask are forced to 0 and mem_stall=0 while rst_n=0.

Test Plan:
- lw, alu_out=0x1000, dmem_resp 3 cycles after request -> rmask=4'b1111 for exactly 1 cycle; mem_stall=1 for 3 cycles; mem_wb.mem_rdata=dmem_rdata; mem_wb.valid=1 once.
- lb, alu_out=0x1003, rdata=0x80xxxxxx -> rmask=4'b1000; mem_rdata=0xFFFFFF80. The same case with lbu gives 0x00000080.
- sh, alu_out=0x2002, rs2_v=0x1234ABCD -> wmask=4'b1100; wdata=0xABCDABCD.
- Same-cycle resp on sw -> mem_stall stays 0; back-to-back add passes with no bubble.
- lh at alu_out=0x3001 -> no mask asserted; mem_wb.misaligned=1; no stall.
- Reset asserted mid-WAIT -> state IDLE, mem_wb.valid=0, mem_stall=0 immediately. After release, a new lw issues normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory loads/stores from the EX/MEM register,
// waits for the response, aligns/extends load data and registers the MEM/WB result.
package mem_stage_pkg;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
        logic        br_en;
        logic [31:0] u_imm;
        logic [5:0]  rd_phys;
        logic [4:0]  rd_arch;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] u_imm;
        logic [5:0]  rd_phys;
        logic [4:0]  rd_arch;
        logic [31:0] mem_rdata;
        logic        misaligned;
    } mem_wb_stage_reg_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ex_mem_stage_reg_t ex_mem,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output mem_wb_stage_reg_t mem_wb,
    output logic              mem_timeout,
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state;
    logic [31:0] wait_cnt;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        aligned_access;
    logic        issue;
    logic [3:0]  base_mask;
    logic [3:0]  lane_mask;
    logic [31:0] shifted_rdata;
    logic [31:0] load_val;
    mem_wb_stage_reg_t wb_next;

    assign opcode   = ex_mem.inst[6:0];
    assign funct3   = ex_mem.inst[14:12];
    assign off      = ex_mem.alu_out[1:0];
    assign is_load  = ex_mem.valid && (opcode == op_load);
    assign is_store = ex_mem.valid && (opcode == op_store);

    // funct3[1:0] encodes access size: 00 byte, 01 half, otherwise word.
    assign misaligned = (is_load || is_store) &&
                        (((funct3[1:0] == 2'b01) && off[0]) ||
                         ((funct3[1:0] != 2'b00) && (funct3[1:0] != 2'b01) && (off != 2'b00)));
    assign aligned_access = (is_load || is_store) && !misaligned;

    always_comb begin
        base_mask  = 4'b1111;
        dmem_wdata = ex_mem.rs2_v;
        case (funct3[1:0])
            2'b00: begin
                base_mask  = 4'b0001;
                dmem_wdata = {4{ex_mem.rs2_v[7:0]}};
            end
            2'b01: begin
                base_mask  = 4'b0011;
                dmem_wdata = {2{ex_mem.rs2_v[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane_mask = base_mask << off;
    assign dmem_addr = {ex_mem.alu_out[31:2], 2'b00};

    // The request is visible for exactly the IDLE cycle; WAIT never reissues it.
    assign issue      = rst_n && (state == IDLE) && aligned_access;
    assign dmem_rmask = (issue && is_load)  ? lane_mask : 4'b0000;
    assign dmem_wmask = (issue && is_store) ? lane_mask : 4'b0000;
    assign mem_stall  = rst_n && !dmem_resp &&
                        (((state == IDLE) && aligned_access) || (state == WAIT));
    assign dbg_state  = (state == WAIT);

    assign shifted_rdata = dmem_rdata >> {off, 3'b000};

    always_comb begin
        load_val = dmem_rdata;
        case (funct3)
            3'b000:  load_val = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b001:  load_val = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  load_val = {24'h0, shifted_rdata[7:0]};
            3'b101:  load_val = {16'h0, shifted_rdata[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_next                = '0;
        wb_next.valid          = ex_mem.valid && !mem_stall;
        wb_next.pc             = ex_mem.pc;
        wb_next.inst           = ex_mem.inst;
        wb_next.rd_s           = ex_mem.rd_s;
        wb_next.regf_we        = ex_mem.regf_we;
        wb_next.regfilemux_sel = ex_mem.regfilemux_sel;
        wb_next.alu_out        = ex_mem.alu_out;
        wb_next.br_en          = ex_mem.br_en;
        wb_next.u_imm          = ex_mem.u_imm;
        wb_next.rd_phys        = ex_mem.rd_phys;
        wb_next.rd_arch        = ex_mem.rd_arch;
        wb_next.mem_rdata      = (is_load && !misaligned) ? load_val : 32'h0;
        wb_next.misaligned     = misaligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            mem_wb      <= '0;
        end else begin
            mem_wb <= wb_next;
            case (state)
                IDLE: begin
                    if (aligned_access && !dmem_resp) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_resp) begin
                        state <= IDLE;
                    end else begin
                        if (wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
                        // Sticky flag only; the access is still allowed to complete.
                        if ((DMEM_TIMEOUT != 0) && (wait_cnt + 32'd1 == DMEM_TIMEOUT))
                            mem_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
